// File: rtl/ddram_responder_pkg.sv
// Shared types and widths for the DDRAM burst responder.
// Holds the FSM state encoding and the burst-count normalisation helper.
package ddram_responder_pkg;

    localparam int BURSTW = 8;
    localparam int DATAW  = 64;
    localparam int BEW    = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_RDRAIN = 2'd2,
        ST_WRITE  = 2'd3
    } state_e;

    // A zero burst count is serviced as a single beat.
    function automatic logic [BURSTW-1:0] eff_beats(input logic [BURSTW-1:0] cnt);
        return (cnt == '0) ? BURSTW'(1) : cnt;
    endfunction

endpackage

// File: rtl/rd_lat_pipe.sv
// Read-valid delay line: vld_out follows vld_in by exactly DEPTH cycles.
// Synchronous clear drops every strobe in flight.
module rd_lat_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic vld_in,
    output logic vld_out
);

    logic [DEPTH-1:0] pipe_q;
    logic [DEPTH-1:0] pipe_d;

    always_comb begin
        pipe_d = (pipe_q << 1) | DEPTH'(vld_in);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign vld_out = pipe_q[DEPTH-1];

endmodule

// File: rtl/ddram_responder.sv
// DDRAM burst slave that turns accepted bursts into single-beat accesses on a
// fixed-latency synchronous memory port; BUSY holds off new requests during reads.
module ddram_responder
    import ddram_responder_pkg::*;
#(
    parameter int ADDRBITS = 24,
    parameter int MEM_LAT  = 2
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [ADDRBITS:0]   DDRAM_ADDR,
    input  logic [DATAW-1:0]    DDRAM_DIN,
    input  logic [BEW-1:0]      DDRAM_BE,
    input  logic [BURSTW-1:0]   DDRAM_BURSTCNT,
    input  logic                DDRAM_RD,
    input  logic                DDRAM_WE,
    output logic [DATAW-1:0]    DDRAM_DOUT,
    output logic                DDRAM_DOUT_READY,
    output logic                DDRAM_BUSY,
    output logic [ADDRBITS:0]   MEM_ADDR,
    output logic [DATAW-1:0]    MEM_DIN,
    output logic [BEW-1:0]      MEM_BE,
    output logic                MEM_WE,
    output logic                MEM_RD,
    input  logic [DATAW-1:0]    MEM_DOUT,
    output logic                ERR
);

    localparam int AW = ADDRBITS + 1;

    state_e            state_q, state_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_we_q, mem_we_d;
    logic [AW-1:0]     mem_addr_q, mem_addr_d;
    logic [DATAW-1:0]  mem_din_q, mem_din_d;
    logic [BEW-1:0]    mem_be_q, mem_be_d;
    logic [BURSTW-1:0] issue_left_q, issue_left_d;
    logic [BURSTW-1:0] rd_left_q, rd_left_d;
    logic [BURSTW-1:0] first_beats;
    logic              dout_ready;

    assign first_beats = eff_beats(DDRAM_BURSTCNT);

    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        err_d        = err_q;
        mem_rd_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;
        mem_be_d     = mem_be_q;
        issue_left_d = issue_left_q;
        rd_left_d    = rd_left_q;

        if (dout_ready && (rd_left_q != '0)) begin
            rd_left_d = rd_left_q - BURSTW'(1);
        end

        // Write beats offered while BUSY is high are never accepted.
        if (DDRAM_WE && busy_q) begin
            err_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (DDRAM_RD && !busy_q) begin
                    mem_rd_d     = 1'b1;
                    mem_addr_d   = DDRAM_ADDR;
                    issue_left_d = first_beats - BURSTW'(1);
                    rd_left_d    = first_beats;
                    busy_d       = 1'b1;
                    state_d      = (first_beats == BURSTW'(1)) ? ST_RDRAIN : ST_READ;
                    if (DDRAM_WE) begin
                        err_d = 1'b1;
                    end
                end else if (DDRAM_WE && !busy_q) begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = DDRAM_ADDR;
                    mem_din_d  = DDRAM_DIN;
                    mem_be_d   = DDRAM_BE;
                    if (first_beats != BURSTW'(1)) begin
                        issue_left_d = first_beats - BURSTW'(1);
                        state_d      = ST_WRITE;
                    end
                end
            end
            ST_READ: begin
                mem_rd_d     = 1'b1;
                mem_addr_d   = mem_addr_q + AW'(1);
                issue_left_d = issue_left_q - BURSTW'(1);
                if (issue_left_q == BURSTW'(1)) begin
                    state_d = ST_RDRAIN;
                end
            end
            ST_RDRAIN: begin
                if (dout_ready && (rd_left_q == BURSTW'(1))) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (DDRAM_RD) begin
                    err_d = 1'b1;
                end
                if (DDRAM_WE) begin
                    mem_we_d     = 1'b1;
                    mem_addr_d   = mem_addr_q + AW'(1);
                    mem_din_d    = DDRAM_DIN;
                    mem_be_d     = DDRAM_BE;
                    issue_left_d = issue_left_q - BURSTW'(1);
                    if (issue_left_q == BURSTW'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
            mem_rd_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            mem_be_q     <= '0;
            issue_left_q <= '0;
            rd_left_q    <= '0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
            mem_rd_q     <= mem_rd_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            mem_be_q     <= mem_be_d;
            issue_left_q <= issue_left_d;
            rd_left_q    <= rd_left_d;
        end
    end

    rd_lat_pipe #(
        .DEPTH (MEM_LAT)
    ) u_rd_lat_pipe (
        .clk     (CLK),
        .rst     (RESET),
        .vld_in  (mem_rd_q),
        .vld_out (dout_ready)
    );

    // Memory data is forwarded in the strobe cycle so each beat lands exactly
    // MEM_LAT cycles after its issue; zero whenever no beat is presented.
    assign DDRAM_DOUT       = dout_ready ? MEM_DOUT : '0;
    assign DDRAM_DOUT_READY = dout_ready;
    assign DDRAM_BUSY       = busy_q;
    assign MEM_ADDR         = mem_addr_q;
    assign MEM_DIN          = mem_din_q;
    assign MEM_BE           = mem_be_q;
    assign MEM_WE           = mem_we_q;
    assign MEM_RD           = mem_rd_q;
    assign ERR              = err_q;

endmodule
